// File: rtl/gray_to_binary_tracker.sv
// -----------------------------------------------------------------------------
// gray_to_binary_tracker
//
// Two-stage pipeline that converts Gray-coded position samples (for example
// from an absolute encoder) to binary, then tracks motion between successive
// samples. A +/-1 step (modulo 2^WIDTH) counts as movement and updates a
// signed position counter. Any larger jump is flagged as an error and counted
// in a saturating error counter.
//
// Ports
//   clk        in   sole clock; all state changes on the rising edge
//   rst        in   synchronous, active-high reset
//   g_in       in   [WIDTH-1:0] Gray-coded sample
//   in_valid   in   g_in is valid this cycle (no backpressure)
//   bin_out    out  [WIDTH-1:0] binary value of the last accepted sample
//   out_valid  out  one-cycle pulse, bin_out was just updated
//   moved      out  one-cycle pulse with out_valid, legal +/-1 step seen
//   dir_up     out  direction of the last legal step (1 = up), held
//   step_err   out  one-cycle pulse with out_valid, illegal jump seen
//   pos_cnt    out  [CNT_W-1:0] two's-complement step count, wraps
//   err_cnt    out  [CNT_W-1:0] illegal jump count, saturates
//
// Latency: a sample taken at edge N is visible on bin_out/out_valid after
// edge N+1.
// -----------------------------------------------------------------------------
module gray_to_binary_tracker #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic             out_valid,
  output logic             moved,
  output logic             dir_up,
  output logic             step_err,
  output logic [CNT_W-1:0] pos_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } track_state_e;

  localparam logic [WIDTH-1:0] DIFF_UP   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DIFF_DOWN = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // Stage 1: captured Gray sample and its valid flag.
  logic [WIDTH-1:0] g_q, g_d;
  logic             s1_valid_q, s1_valid_d;

  // Stage 2: converted value, tracker state and registered outputs.
  track_state_e     state_q, state_d;
  logic [WIDTH-1:0] prev_bin_q, prev_bin_d;
  logic [WIDTH-1:0] bin_out_q, bin_out_d;
  logic             out_valid_q, out_valid_d;
  logic             moved_q, moved_d;
  logic             dir_up_q, dir_up_d;
  logic             step_err_q, step_err_d;
  logic [CNT_W-1:0] pos_cnt_q, pos_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [WIDTH-1:0] new_bin;
  logic [WIDTH-1:0] diff;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    g_d         = in_valid ? g_in : g_q;
    s1_valid_d  = in_valid;

    state_d     = state_q;
    prev_bin_d  = prev_bin_q;
    bin_out_d   = bin_out_q;
    out_valid_d = 1'b0;
    moved_d     = 1'b0;
    step_err_d  = 1'b0;
    dir_up_d    = dir_up_q;
    pos_cnt_d   = pos_cnt_q;
    err_cnt_d   = err_cnt_q;

    new_bin     = gray_to_bin(g_q);
    // Modular subtraction: wrap 15->0 yields 1 (up), 0->15 yields all-ones (down).
    diff        = new_bin - prev_bin_q;

    if (s1_valid_q) begin
      bin_out_d   = new_bin;
      out_valid_d = 1'b1;
      prev_bin_d  = new_bin;
      case (state_q)
        UNPRIMED: begin
          // First sample only establishes the reference position.
          state_d = TRACK;
        end
        TRACK: begin
          if (diff == DIFF_UP) begin
            moved_d   = 1'b1;
            dir_up_d  = 1'b1;
            pos_cnt_d = pos_cnt_q + CNT_ONE;
          end else if (diff == DIFF_DOWN) begin
            moved_d   = 1'b1;
            dir_up_d  = 1'b0;
            pos_cnt_d = pos_cnt_q - CNT_ONE;
          end else if (diff != '0) begin
            step_err_d = 1'b1;
            if (err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNT_ONE;
            end
          end
        end
        default: state_d = UNPRIMED;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: the Gray data register is qualified by s1_valid_q, so it needs no
    // reset; only control and architectural state are cleared.
    g_q <= g_d;
    if (rst) begin
      s1_valid_q  <= 1'b0;
      state_q     <= UNPRIMED;
      prev_bin_q  <= '0;
      bin_out_q   <= '0;
      out_valid_q <= 1'b0;
      moved_q     <= 1'b0;
      dir_up_q    <= 1'b0;
      step_err_q  <= 1'b0;
      pos_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      state_q     <= state_d;
      prev_bin_q  <= prev_bin_d;
      bin_out_q   <= bin_out_d;
      out_valid_q <= out_valid_d;
      moved_q     <= moved_d;
      dir_up_q    <= dir_up_d;
      step_err_q  <= step_err_d;
      pos_cnt_q   <= pos_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bin_out   = bin_out_q;
  assign out_valid = out_valid_q;
  assign moved     = moved_q;
  assign dir_up    = dir_up_q;
  assign step_err  = step_err_q;
  assign pos_cnt   = pos_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_gray_to_binary_tracker.sv
// -----------------------------------------------------------------------------
// tb_gray_to_binary_tracker
//
// Drives directed scenarios and a long randomized encoder walk into
// gray_to_binary_tracker. A behavioural model (integer arithmetic on sample
// history) predicts every output; a compare process checks all outputs on each
// falling edge, and directed scenarios pin the model with literal values.
// -----------------------------------------------------------------------------
module tb_gray_to_binary_tracker;

  localparam int W = 4;
  localparam int C = 8;
  localparam int NPOS = 1 << W;
  localparam int NCNT = 1 << C;

  logic         clk;
  logic         rst;
  logic [W-1:0] g_in;
  logic         in_valid;
  logic [W-1:0] bin_out;
  logic         out_valid;
  logic         moved;
  logic         dir_up;
  logic         step_err;
  logic [C-1:0] pos_cnt;
  logic [C-1:0] err_cnt;

  gray_to_binary_tracker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .g_in     (g_in),
    .in_valid (in_valid),
    .bin_out  (bin_out),
    .out_valid(out_valid),
    .moved    (moved),
    .dir_up   (dir_up),
    .step_err (step_err),
    .pos_cnt  (pos_cnt),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit ready = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int to_gray(input int b);
    return (b ^ (b >> 1)) % NPOS;
  endfunction

  // Inverse Gray by search: the unique binary value whose Gray code matches.
  function automatic int from_gray(input int g);
    for (int b = 0; b < NPOS; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  // ---------------- behavioural model ----------------
  int m_bin = 0, m_ov = 0, m_mv = 0, m_dir = 0, m_se = 0, m_pos = 0, m_err = 0;
  int m_prev = 0;
  bit m_primed = 1'b0;
  bit pend_v = 1'b0;
  int pend_g = 0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_bin = 0; m_ov = 0; m_mv = 0; m_dir = 0; m_se = 0;
        m_pos = 0; m_err = 0; m_prev = 0; m_primed = 1'b0; pend_v = 1'b0;
      end else begin
        m_ov = 0; m_mv = 0; m_se = 0;
        if (pend_v) begin
          int b, d;
          b = from_gray(pend_g);
          m_bin = b;
          m_ov = 1;
          if (!m_primed) begin
            m_primed = 1'b1;
          end else begin
            d = (b - m_prev + NPOS) % NPOS;
            if (d == 1) begin
              m_mv = 1; m_dir = 1; m_pos = (m_pos + 1) % NCNT;
            end else if (d == NPOS - 1) begin
              m_mv = 1; m_dir = 0; m_pos = (m_pos + NCNT - 1) % NCNT;
            end else if (d != 0) begin
              m_se = 1;
              if (m_err < NCNT - 1) m_err = m_err + 1;
            end
          end
          m_prev = b;
        end
        pend_v = in_valid;
        pend_g = int'(g_in);
      end
    end
  end

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (ready) begin
        check("bin_out",   int'(bin_out),   m_bin);
        check("out_valid", int'(out_valid), m_ov);
        check("moved",     int'(moved),     m_mv);
        check("dir_up",    int'(dir_up),    m_dir);
        check("step_err",  int'(step_err),  m_se);
        check("pos_cnt",   int'(pos_cnt),   m_pos);
        check("err_cnt",   int'(err_cnt),   m_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  // Apply inputs, then wait until the falling edge after the next rising edge.
  task automatic drive(input bit v, input int g);
    in_valid = v;
    g_in     = W'(g);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst      = 1'b0;
  endtask

  initial begin
    int cur_b;
    rst = 1'b1; in_valid = 1'b0; g_in = '0;
    @(negedge clk);
    do_reset();
    ready = 1'b1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset pos_cnt",   int'(pos_cnt),   0);
    check("reset err_cnt",   int'(err_cnt),   0);

    // Single sample primes only.
    drive(1, 0);
    drive(0, 0);
    check("prime out_valid", int'(out_valid), 1);
    check("prime bin_out",   int'(bin_out),   0);
    check("prime moved",     int'(moved),     0);
    check("prime step_err",  int'(step_err),  0);
    check("prime pos_cnt",   int'(pos_cnt),   0);

    // Counting up through Gray 0000,0001,0011,0010.
    do_reset();
    drive(1, 4'b0000);
    drive(1, 4'b0001);
    check("up0 bin_out", int'(bin_out), 0);
    check("up0 moved",   int'(moved),   0);
    drive(1, 4'b0011);
    check("up1 bin_out", int'(bin_out), 1);
    check("up1 moved",   int'(moved),   1);
    drive(1, 4'b0010);
    check("up2 bin_out", int'(bin_out), 2);
    drive(0, 0);
    check("up3 bin_out", int'(bin_out), 3);
    check("up3 moved",   int'(moved),   1);
    check("up3 dir_up",  int'(dir_up),  1);
    check("up3 pos_cnt", int'(pos_cnt), 3);

    // Down-wrap 0 -> 15, then up-wrap 15 -> 0.
    do_reset();
    drive(1, 4'b0000);
    drive(1, 4'b1000);
    drive(1, 4'b0000);
    check("dn bin_out",  int'(bin_out), 15);
    check("dn moved",    int'(moved),   1);
    check("dn dir_up",   int'(dir_up),  0);
    check("dn pos_cnt",  int'(pos_cnt), 8'hFF);
    drive(0, 0);
    check("wrapup dir_up",  int'(dir_up),  1);
    check("wrapup pos_cnt", int'(pos_cnt), 0);

    // Illegal jumps.
    do_reset();
    drive(1, 4'b0000);
    drive(1, 4'b0011);
    drive(1, 4'b0110);
    check("jmp bin_out",  int'(bin_out),  2);
    check("jmp step_err", int'(step_err), 1);
    check("jmp moved",    int'(moved),    0);
    check("jmp err_cnt",  int'(err_cnt),  1);
    check("jmp pos_cnt",  int'(pos_cnt),  0);
    drive(0, 0);
    check("jmp2 bin_out",  int'(bin_out),  4);
    check("jmp2 step_err", int'(step_err), 1);
    check("jmp2 err_cnt",  int'(err_cnt),  2);

    // Reset discards a sample in flight.
    do_reset();
    drive(1, 4'b0101);
    do_reset();
    check("flush out_valid", int'(out_valid), 0);
    drive(0, 0);
    check("flush out_valid2", int'(out_valid), 0);
    drive(1, 4'b0001);
    drive(1, 4'b0011);
    check("reprime moved",   int'(moved),   0);
    check("reprime pos_cnt", int'(pos_cnt), 0);
    drive(0, 0);
    check("after moved",   int'(moved),   1);
    check("after pos_cnt", int'(pos_cnt), 1);

    // Repeated identical samples with gaps, then error saturation.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 4'b0001);
      drive(0, 0);
      check("hold out_valid", int'(out_valid), 1);
      check("hold moved",     int'(moved),     0);
      check("hold step_err",  int'(step_err),  0);
      check("hold pos_cnt",   int'(pos_cnt),   0);
    end
    for (int i = 0; i < 300; i++) begin
      drive(1, (i % 2 == 0) ? 4'b0000 : 4'b0011);
    end
    drive(0, 0);
    check("sat err_cnt", int'(err_cnt), 8'hFF);

    // Randomized encoder walk with occasional large jumps and resets.
    do_reset();
    cur_b = 0;
    for (int i = 0; i < 4000; i++) begin
      int k;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        k = int'($urandom_range(0, 9));
        if (k <= 3)      cur_b = (cur_b + 1) % NPOS;
        else if (k <= 6) cur_b = (cur_b + NPOS - 1) % NPOS;
        else if (k >= 8) cur_b = int'($urandom_range(0, NPOS - 1));
        drive($urandom_range(0, 9) < 8, to_gray(cur_b));
      end
    end
    drive(0, 0);
    drive(0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_to_binary_tracker.md
GRAY_TO_BINARY_TRACKER -- requirements
Module: gray_to_binary_tracker

Interface
REQ-001 Parameter WIDTH, default 4: width of Gray input and binary output.
REQ-002 Parameter CNT_W, default 8: width of position and error counters.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 g_in  input  WIDTH  Gray-coded position sample.
REQ-006 in_valid  input  1  g_in valid this cycle; one sample accepted per cycle, no backpressure.
REQ-007 bin_out  output  WIDTH  binary equivalent of last accepted sample.
REQ-008 out_valid  output  1  one-cycle pulse: bin_out updated.
REQ-009 moved  output  1  one-cycle pulse with out_valid: legal +/-1 step detected.
REQ-010 dir_up  output  1  direction of last legal step (1 = up, 0 = down); held between steps.
REQ-011 step_err  output  1  one-cycle pulse with out_valid: illegal jump detected.
REQ-012 pos_cnt  output  CNT_W  signed two's-complement accumulated step count.
REQ-013 err_cnt  output  CNT_W  count of illegal jumps, saturating.

Function
REQ-014 Stage 1 SHALL register g_in and a stage-valid flag on every edge where in_valid=1; stage-valid SHALL clear on edges where in_valid=0.
REQ-015 Stage 2 SHALL convert the stage-1 Gray value to binary (b[MSB]=g[MSB]; b[i]=b[i+1] XOR g[i]) and load bin_out, asserting out_valid for exactly one cycle.
REQ-016 Latency SHALL be 2 cycles: sample taken at edge N appears on bin_out/out_valid after edge N+1; back-to-back samples every cycle SHALL produce out_valid every cycle.
REQ-017 Tracker FSM SHALL have states UNPRIMED and TRACK; reset enters UNPRIMED.
REQ-018 UNPRIMED: first converted sample SHALL be stored as reference prev_bin, moved=0, step_err=0, counters unchanged; transition to TRACK.
REQ-019 TRACK: diff = (new_bin - prev_bin) mod 2^WIDTH computed on each converted sample; prev_bin SHALL update to new_bin in every case.
REQ-020 diff=0: hold; moved=0, step_err=0, pos_cnt and dir_up unchanged.
REQ-021 diff=1: moved=1, dir_up=1, pos_cnt incremented.
REQ-022 diff=2^WIDTH-1: moved=1, dir_up=0, pos_cnt decremented.
REQ-023 Any other diff: step_err=1, moved=0, err_cnt incremented, pos_cnt and dir_up unchanged.
REQ-024 Binary wrap 15->0 SHALL count as up and 0->15 as down (WIDTH=4).
REQ-025 pos_cnt SHALL wrap modulo 2^CNT_W; err_cnt SHALL saturate at 2^CNT_W-1.
REQ-026 moved, step_err SHALL be 0 in every cycle where out_valid=0.
REQ-027 FSM SHALL remain in TRACK until reset; no other transition exists.

Reset
REQ-028 rst=1 at an edge SHALL clear bin_out, out_valid, moved, dir_up, step_err, pos_cnt, err_cnt, prev_bin, both stage-valid flags, and set FSM to UNPRIMED.
REQ-029 rst SHALL take priority over in_valid on the same edge; samples in flight SHALL be discarded with no out_valid.
REQ-030 First sample after reset release SHALL prime only (REQ-018), never pulse moved or step_err.

Verification
REQ-031 Reset, then g_in=0000 valid one cycle -> two edges later bin_out=0000, out_valid=1, moved=0, step_err=0, pos_cnt=0.
REQ-032 Consecutive cycles g_in=0000,0001,0011,0010 -> bin_out 0,1,2,3 on consecutive cycles, moved pulses on last three, dir_up=1, pos_cnt=3.
REQ-033 Primed at 0000, then g_in=1000 -> bin_out=1111, moved=1, dir_up=0, pos_cnt=8'hFF; then g_in=0000 -> dir_up=1, pos_cnt=0.
REQ-034 Primed at 0000, then g_in=0011 -> bin_out=0010, step_err=1, moved=0, err_cnt=1, pos_cnt=0; then g_in=0110 (bin 4) -> step_err=1, err_cnt=2.
REQ-035 Sample accepted, rst asserted next edge -> no out_valid; subsequent g_in=0001 primes (moved=0, pos_cnt=0), then g_in=0011 -> moved=1, pos_cnt=1.
REQ-036 Repeated g_in=0001 with in_valid gaps -> out_valid per sample, moved=0, step_err=0, pos_cnt unchanged; 256 illegal jumps -> err_cnt holds 8'hFF.
